// File: rtl/serial_cmd_pkg.sv
// Shared constants, parser state encoding and reply payload type for the serial command endpoint.
package serial_cmd_pkg;

    localparam logic [7:0] SOF             = 8'hFF;
    localparam logic [7:0] SPACE           = 8'h00;
    localparam logic [7:0] EOF             = 8'hEE;
    localparam logic [7:0] CMD_WRITE       = 8'h01;
    localparam logic [7:0] CMD_READ        = 8'h02;
    localparam logic [7:0] ERR_FLAG        = 8'h80;
    localparam logic [7:0] ERR_UNKNOWN_CMD = 8'h01;
    localparam logic [7:0] ERR_BAD_REG     = 8'h02;
    localparam logic [7:0] ERR_BAD_LEN     = 8'h03;

    typedef enum logic [2:0] {
        ST_HUNT_SOF1,
        ST_SOF2,
        ST_SPACE,
        ST_LEN,
        ST_PAYLOAD,
        ST_EOF1,
        ST_EOF2,
        ST_EXEC
    } parse_state_t;

    // Reply payload: 2 or 3 bytes, b2 only meaningful when len == 3.
    typedef struct packed {
        logic [1:0] len;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } reply_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_transceiver.sv
// 8E1 UART: mid-bit sampling deserialiser and a serialiser that can chain bytes with no idle gap.
module uart_transceiver
    import serial_cmd_pkg::*;
#(
    parameter int unsigned BIT_TICKS = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    output logic       o_rx_err,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ready_c,
    output logic       o_tx_busy,
    output logic       o_tx
);

    localparam int unsigned CNT_W = $clog2(BIT_TICKS + 1);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(BIT_TICKS / 2 - 1);
    localparam logic [3:0] IDX_PARITY = 4'd9;
    localparam logic [3:0] IDX_STOP   = 4'd10;

    logic             r_rx_meta, r_rx_sync, r_rx_prev;
    logic             r_rx_busy, r_rx_par, r_rx_valid, r_rx_err;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [3:0]       r_rx_idx;
    logic [7:0]       r_rx_shift;

    logic             r_tx, r_tx_busy, r_tx_par;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [3:0]       r_tx_idx;
    logic [7:0]       r_tx_shift;
    logic             w_tx_ready, w_tx_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Index 0 is the start bit (confirmed at half a bit), 1..8 data, 9 parity, 10 stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_busy  <= 1'b0;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (!r_rx_busy) begin
                if (r_rx_prev && !r_rx_sync) begin
                    r_rx_busy <= 1'b1;
                    r_rx_cnt  <= '0;
                    r_rx_idx  <= '0;
                end
            end else if (r_rx_idx == 4'd0) begin
                if (r_rx_cnt == HALF_TICK) begin
                    r_rx_cnt <= '0;
                    if (!r_rx_sync) r_rx_idx  <= 4'd1;
                    else            r_rx_busy <= 1'b0;
                end else begin
                    r_rx_cnt <= r_rx_cnt + 1'b1;
                end
            end else if (r_rx_cnt == LAST_TICK) begin
                r_rx_cnt <= '0;
                r_rx_idx <= r_rx_idx + 4'd1;
                if (r_rx_idx < IDX_PARITY) begin
                    r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                end else if (r_rx_idx == IDX_PARITY) begin
                    r_rx_par <= r_rx_sync;
                end else begin
                    r_rx_busy  <= 1'b0;
                    r_rx_valid <= 1'b1;
                    r_rx_err   <= (r_rx_par != even_parity(r_rx_shift)) || !r_rx_sync;
                end
            end else begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end
        end
    end

    // Ready also in the last tick of a stop bit so the next start bit follows without a gap.
    assign w_tx_ready = !r_tx_busy || (r_tx_idx == IDX_STOP && r_tx_cnt == LAST_TICK);

    always_comb begin
        w_tx_bit = 1'b1;
        if (r_tx_idx < 4'd8)       w_tx_bit = r_tx_shift[r_tx_idx[2:0]];
        else if (r_tx_idx == 4'd8) w_tx_bit = r_tx_par;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
        end else if (i_tx_start && w_tx_ready) begin
            r_tx       <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= i_tx_data;
            r_tx_par   <= even_parity(i_tx_data);
        end else if (r_tx_busy) begin
            if (r_tx_cnt == LAST_TICK) begin
                r_tx_cnt <= '0;
                if (r_tx_idx == IDX_STOP) begin
                    r_tx_busy <= 1'b0;
                end else begin
                    r_tx_idx <= r_tx_idx + 4'd1;
                    r_tx     <= w_tx_bit;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

    assign o_rx_valid   = r_rx_valid;
    assign o_rx_data    = r_rx_shift;
    assign o_rx_err     = r_rx_err;
    assign o_tx_ready_c = w_tx_ready;
    assign o_tx_busy    = r_tx_busy;
    assign o_tx         = r_tx;

endmodule

// File: rtl/serial_cmd_processor.sv
// UART command endpoint: frame parser, 16x8 register file and framed reply builder.
module serial_cmd_processor
    import serial_cmd_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD_RATE   = 115_200,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned MAX_PAYLOAD = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic tx,
    input  logic rts,
    output logic cts
);

    localparam int unsigned BIT_TICKS = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned GAP_TICKS = 16 * BIT_TICKS;
    localparam int unsigned GAP_W     = $clog2(GAP_TICKS + 1);
    localparam int unsigned REG_W     = $clog2(NUM_REGS);

    parse_state_t     r_state, w_state_next;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [7:0]       r_len, r_pay_cnt, r_cmd, r_reg, r_val;
    logic [7:0]       r_regs [NUM_REGS];
    reply_t           r_rep, w_reply;
    logic [3:0]       r_rep_idx, w_rep_total;
    logic             r_rep_active, r_cts, r_rts_meta, r_rts_sync;

    logic       w_rx_valid, w_rx_err, w_tx_ready_c, w_tx_busy, w_tx_start, w_do_write;
    logic       w_byte_ev, w_byte_ok, w_gap_expired, w_reg_ok;
    logic [7:0] w_rx_data, w_tx_byte;

    uart_transceiver #(.BIT_TICKS(BIT_TICKS)) u_uart (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rx         (rx),
        .o_rx_valid   (w_rx_valid),
        .o_rx_data    (w_rx_data),
        .o_rx_err     (w_rx_err),
        .i_tx_start   (w_tx_start),
        .i_tx_data    (w_tx_byte),
        .o_tx_ready_c (w_tx_ready_c),
        .o_tx_busy    (w_tx_busy),
        .o_tx         (tx)
    );

    // Bytes landing while a reply is pending are deliberately invisible to the parser.
    assign w_byte_ev     = w_rx_valid && r_cts;
    assign w_byte_ok     = w_byte_ev && !w_rx_err;
    assign w_gap_expired = (r_gap_cnt == GAP_W'(GAP_TICKS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_HUNT_SOF1;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HUNT_SOF1: if (w_byte_ok && w_rx_data == SOF) w_state_next = ST_SOF2;
            ST_SOF2:      if (w_byte_ev) w_state_next = (w_byte_ok && w_rx_data == SOF)   ? ST_SPACE : ST_HUNT_SOF1;
            ST_SPACE:     if (w_byte_ev) w_state_next = (w_byte_ok && w_rx_data == SPACE) ? ST_LEN   : ST_HUNT_SOF1;
            ST_LEN:       if (w_byte_ev) w_state_next = (w_byte_ok && w_rx_data != 8'd0 &&
                                                         w_rx_data <= 8'(MAX_PAYLOAD)) ? ST_PAYLOAD : ST_HUNT_SOF1;
            ST_PAYLOAD:   if (w_byte_ev) w_state_next = !w_byte_ok ? ST_HUNT_SOF1 :
                                                        (r_pay_cnt == r_len - 8'd1) ? ST_EOF1 : ST_PAYLOAD;
            ST_EOF1:      if (w_byte_ev) w_state_next = (w_byte_ok && w_rx_data == EOF) ? ST_EOF2 : ST_HUNT_SOF1;
            ST_EOF2:      if (w_byte_ev) w_state_next = (w_byte_ok && w_rx_data == EOF) ? ST_EXEC : ST_HUNT_SOF1;
            default:      w_state_next = ST_HUNT_SOF1;
        endcase
        if (r_state != ST_HUNT_SOF1 && r_state != ST_EXEC && w_gap_expired)
            w_state_next = ST_HUNT_SOF1;
    end

    // Command decode: unknown command wins over length, length over register range.
    assign w_reg_ok = (r_reg < 8'(NUM_REGS));

    always_comb begin
        w_do_write = 1'b0;
        w_reply    = '{len: 2'd2, b0: r_cmd | ERR_FLAG, b1: ERR_UNKNOWN_CMD, b2: 8'h00};
        if (r_cmd == CMD_WRITE || r_cmd == CMD_READ) begin
            if (r_len != ((r_cmd == CMD_WRITE) ? 8'd3 : 8'd2)) begin
                w_reply.b1 = ERR_BAD_LEN;
            end else if (!w_reg_ok) begin
                w_reply.b1 = ERR_BAD_REG;
            end else begin
                w_reply.len = 2'd3;
                w_reply.b0  = r_cmd;
                w_reply.b1  = r_reg;
                w_reply.b2  = (r_cmd == CMD_WRITE) ? r_val : r_regs[r_reg[REG_W-1:0]];
                w_do_write  = (r_cmd == CMD_WRITE);
            end
        end
    end

    assign w_rep_total = 4'd6 + {2'b00, r_rep.len};
    assign w_tx_start  = r_rep_active && (r_rep_idx != w_rep_total) && r_rts_sync && w_tx_ready_c;

    always_comb begin
        w_tx_byte = EOF;
        case (r_rep_idx)
            4'd0, 4'd1: w_tx_byte = SOF;
            4'd2:       w_tx_byte = SPACE;
            4'd3:       w_tx_byte = {6'd0, r_rep.len};
            4'd4:       w_tx_byte = r_rep.b0;
            4'd5:       w_tx_byte = r_rep.b1;
            4'd6:       w_tx_byte = (r_rep.len == 2'd3) ? r_rep.b2 : EOF;
            default:    w_tx_byte = EOF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_cnt    <= '0;
            r_len        <= '0;
            r_pay_cnt    <= '0;
            r_cmd        <= '0;
            r_reg        <= '0;
            r_val        <= '0;
            r_rep        <= '0;
            r_rep_idx    <= '0;
            r_rep_active <= 1'b0;
            r_cts        <= 1'b1;
            r_rts_meta   <= 1'b0;
            r_rts_sync   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_rts_meta <= rts;
            r_rts_sync <= r_rts_meta;

            if (r_state == ST_HUNT_SOF1 || r_state == ST_EXEC || w_byte_ev) r_gap_cnt <= '0;
            else if (!w_gap_expired)                                          r_gap_cnt <= r_gap_cnt + 1'b1;

            if (w_byte_ok && r_state == ST_LEN) begin
                r_len     <= w_rx_data;
                r_pay_cnt <= '0;
            end
            if (w_byte_ok && r_state == ST_PAYLOAD) begin
                case (r_pay_cnt)
                    8'd0:    r_cmd <= w_rx_data;
                    8'd1:    r_reg <= w_rx_data;
                    8'd2:    r_val <= w_rx_data;
                    default: ;
                endcase
                r_pay_cnt <= r_pay_cnt + 8'd1;
            end

            if (r_state == ST_EXEC) begin
                r_rep        <= w_reply;
                r_rep_idx    <= '0;
                r_rep_active <= 1'b1;
                if (w_do_write) r_regs[r_reg[REG_W-1:0]] <= r_val;
            end else if (r_rep_active) begin
                if (w_tx_start) begin
                    r_rep_idx <= r_rep_idx + 4'd1;
                end else if (r_rep_idx == w_rep_total && !w_tx_busy) begin
                    r_rep_active <= 1'b0;
                    r_cts        <= 1'b1;
                end
            end

            if (w_state_next == ST_EXEC && r_state != ST_EXEC) r_cts <= 1'b0;
        end
    end

    assign cts = r_cts;

endmodule

// File: tb/tb_serial_cmd_processor.sv
// Directed bench: drives framed commands on rx and decodes the tx line against hand-computed replies.
module tb_serial_cmd_processor;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 125_000;
    localparam int BIT             = CLK_HZ / BAUD;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] d;
        logic       ok;
        logic       cts;
        int         t;
    } mon_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic rts = 1'b1;
    logic tx, cts;

    int   cyc = 0;
    mon_t rxq[$];
    int   rd = 0;
    int   t_end = 0;
    int   n_vec = 0;
    int   n_err = 0;

    serial_cmd_processor #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD),
        .NUM_REGS    (16),
        .MAX_PAYLOAD (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .tx    (tx),
        .rts   (rts),
        .cts   (cts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder for tx, sampling on the falling clock edge.
    initial begin
        mon_t       m;
        logic [7:0] d;
        logic       p, s;
        forever begin
            @(negedge clk);
            if (rst_n && tx == 1'b0) begin
                m.t = cyc;
                repeat (BIT / 2) @(negedge clk);
                m.ok  = (tx == 1'b0);
                m.cts = cts;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    d[i] = tx;
                end
                repeat (BIT) @(negedge clk);
                p = tx;
                repeat (BIT) @(negedge clk);
                s = tx;
                m.d  = d;
                m.ok = m.ok && (p == ^d) && s;
                rxq.push_back(m);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        logic [10:0] bits;
        bits = {1'b1, (^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            repeat (BIT) @(posedge clk);
        end
    endtask

    task automatic send_frame(input bq_t f, input int bad_idx);
        foreach (f[i]) send_byte(f[i], i == bad_idx);
        t_end = cyc;
    endtask

    task automatic expect_reply(input string tag, input bq_t e, input bit chk_lat);
        int n;
        int waited;
        int got;
        n = e.size();
        waited = 0;
        while (rxq.size() - rd < n && waited < n * 11 * BIT + 40 * BIT) begin
            @(posedge clk);
            waited++;
        end
        got = rxq.size() - rd;
        check({tag, ".count"}, 32'(got), 32'(n));
        for (int i = 0; i < n && i < got; i++) begin
            check($sformatf("%s.b%0d", tag, i), 32'(rxq[rd + i].d), 32'(e[i]));
            check($sformatf("%s.frm%0d", tag, i), 32'(rxq[rd + i].ok), 32'd1);
            check($sformatf("%s.cts%0d", tag, i), 32'(rxq[rd + i].cts), 32'd0);
            if (i > 0)
                check($sformatf("%s.gap%0d", tag, i), 32'(rxq[rd + i].t - rxq[rd + i - 1].t), 32'(11 * BIT));
        end
        if (chk_lat && got > 0)
            check({tag, ".latency"}, 32'(rxq[rd].t - t_end <= 6), 32'd1);
        repeat (2 * BIT) @(negedge clk);
        check({tag, ".cts_after"}, 32'(cts), 32'd1);
        check({tag, ".extra"}, 32'(rxq.size() - rd), 32'(n));
        rd = rxq.size();
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int lows;
        lows = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
        check({tag, ".tx_low"}, 32'(lows), 32'd0);
        check({tag, ".bytes"}, 32'(rxq.size() - rd), 32'd0);
    endtask

    initial begin
        bq_t fr, ex;
        int  w;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.tx", 32'(tx), 32'd1);
        check("reset.cts", 32'(cts), 32'd1);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        fr = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h02, 8'h03, 8'hEE, 8'hEE};
        ex = '{8'hFF, 8'hFF, 8'h00, 8'h03, 8'h02, 8'h03, 8'h00, 8'hEE, 8'hEE};
        send_frame(fr, -1);
        expect_reply("rd3", ex, 1'b1);

        fr = '{8'hFF, 8'hFF, 8'h00, 8'h03, 8'h01, 8'h05, 8'hA5, 8'hEE, 8'hEE};
        ex = '{8'hFF, 8'hFF, 8'h00, 8'h03, 8'h01, 8'h05, 8'hA5, 8'hEE, 8'hEE};
        send_frame(fr, -1);
        expect_reply("wr5", ex, 1'b1);

        fr = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h02, 8'h05, 8'hEE, 8'hEE};
        ex = '{8'hFF, 8'hFF, 8'h00, 8'h03, 8'h02, 8'h05, 8'hA5, 8'hEE, 8'hEE};
        send_frame(fr, -1);
        expect_reply("rd5", ex, 1'b1);

        fr = '{8'hFF, 8'hFF, 8'h00, 8'h03, 8'h01, 8'h0F, 8'h3C, 8'hEE, 8'hEE};
        ex = '{8'hFF, 8'hFF, 8'h00, 8'h03, 8'h01, 8'h0F, 8'h3C, 8'hEE, 8'hEE};
        send_frame(fr, -1);
        expect_reply("wr15", ex, 1'b1);

        fr = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h02, 8'h0F, 8'hEE, 8'hEE};
        ex = '{8'hFF, 8'hFF, 8'h00, 8'h03, 8'h02, 8'h0F, 8'h3C, 8'hEE, 8'hEE};
        send_frame(fr, -1);
        expect_reply("rd15", ex, 1'b1);

        fr = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h02, 8'h10, 8'hEE, 8'hEE};
        ex = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h82, 8'h02, 8'hEE, 8'hEE};
        send_frame(fr, -1);
        expect_reply("rd16", ex, 1'b1);

        fr = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h02, 8'h12, 8'hEE, 8'hEE};
        send_frame(fr, -1);
        expect_reply("rd18", ex, 1'b1);

        fr = '{8'hFF, 8'hFF, 8'h00, 8'h01, 8'h07, 8'hEE, 8'hEE};
        ex = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h87, 8'h01, 8'hEE, 8'hEE};
        send_frame(fr, -1);
        expect_reply("cmd7", ex, 1'b1);

        fr = '{8'hFF, 8'hFF, 8'h00, 8'h03, 8'h02, 8'h05, 8'h00, 8'hEE, 8'hEE};
        ex = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h82, 8'h03, 8'hEE, 8'hEE};
        send_frame(fr, -1);
        expect_reply("rdlen3", ex, 1'b1);

        fr = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h02, 8'h05, 8'hEE, 8'hEE};
        send_frame(fr, 3);
        expect_quiet("badpar", 30 * BIT);

        fr = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h02, 8'h05, 8'hEE, 8'hEF};
        send_frame(fr, -1);
        expect_quiet("badeof", 30 * BIT);

        fr = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hEE, 8'hEE};
        send_frame(fr, -1);
        expect_quiet("len0", 30 * BIT);

        fr = '{8'hFF, 8'hFF, 8'h00, 8'h11, 8'hEE, 8'hEE};
        send_frame(fr, -1);
        expect_quiet("len17", 30 * BIT);

        fr = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h02, 8'h05};
        send_frame(fr, -1);
        repeat (20 * BIT) @(posedge clk);
        fr = '{8'hEE, 8'hEE};
        send_frame(fr, -1);
        expect_quiet("gap", 30 * BIT);

        fr = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h02, 8'h05, 8'hEE, 8'hEE};
        ex = '{8'hFF, 8'hFF, 8'h00, 8'h03, 8'h02, 8'h05, 8'hA5, 8'hEE, 8'hEE};
        send_frame(fr, -1);
        expect_reply("recover", ex, 1'b1);

        rts = 1'b0;
        send_frame(fr, -1);
        expect_quiet("rtshold", 40 * BIT);
        check("rtshold.cts", 32'(cts), 32'd0);
        rts = 1'b1;
        expect_reply("rtsrel", ex, 1'b0);

        send_frame(fr, -1);
        w = 0;
        while (rxq.size() - rd < 3 && w < 60 * BIT) begin
            @(posedge clk);
            w++;
        end
        check("midrst.started", 32'(rxq.size() - rd >= 3), 32'd1);
        repeat (3 * BIT) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.tx", 32'(tx), 32'd1);
        check("midrst.cts", 32'(cts), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15 * BIT) @(posedge clk);
        rd = rxq.size();
        expect_quiet("midrst", 20 * BIT);

        ex = '{8'hFF, 8'hFF, 8'h00, 8'h03, 8'h02, 8'h05, 8'h00, 8'hEE, 8'hEE};
        send_frame(fr, -1);
        expect_reply("rd5rst", ex, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
